// File: rtl/esm_issue_scheduler.sv
// esm_issue_scheduler
//   Issue controller for the ESM instruction buffer. It picks one eligible entry at a time
//   from the independent-instruction mask. The scan starts at an offset and wraps from
//   bs-1 to 0. The block tracks in-flight (busy) entries until they retire. It presents the
//   chosen index to the execute stage over a valid/ready handshake.
//
//   Optional feature macro: ESM_SCHED_ROUND_ROBIN_EN
//     defined   : scan offset = (last accepted index + 1) mod bs; random_number is ignored
//     undefined : scan offset = random_number, sampled in SCAN
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   proceed             issue request (level, sampled in IDLE)
//   flush               clear busy mask and abort any pending issue
//   independent_instr   [0:bs-1] ready mask, bit i = entry i
//   random_number       PRNG scan start offset
//   issue_ready         downstream accepts this cycle
//   retire_valid/index  completion of an in-flight entry
//   issue_valid/index   offered entry, held until accepted
//   busy_mask           [0:bs-1] in-flight entries
//   issued_count        accepted issues (saturating)
//   stall_count         IDLE cycles with proceed and nothing eligible (saturating)
module esm_issue_scheduler #(
  parameter  int bs      = 16,
  parameter  int CNT_W   = 16,
  localparam int BS_BITS = $clog2(bs)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               proceed,
  input  logic               flush,
  input  logic [0:bs-1]      independent_instr,
  input  logic [BS_BITS-1:0] random_number,
  input  logic               issue_ready,
  input  logic               retire_valid,
  input  logic [BS_BITS-1:0] retire_index,
  output logic               issue_valid,
  output logic [BS_BITS-1:0] issue_index,
  output logic [0:bs-1]      busy_mask,
  output logic [CNT_W-1:0]   issued_count,
  output logic [CNT_W-1:0]   stall_count
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ISSUE} state_t;

  state_t             state, state_next;
  logic [0:bs-1]      eligible;
  logic               any_elig;
  logic [BS_BITS-1:0] offset;
  logic [BS_BITS-1:0] scan_idx;
  logic [BS_BITS-1:0] sel_idx;
  logic               sel_hit;
  logic               accept;
  logic               load_idx;
  logic               stall_inc;
  logic [0:bs-1]      busy_next;

  assign eligible = independent_instr & ~busy_mask;
  assign any_elig = |eligible;

`ifdef ESM_SCHED_ROUND_ROBIN_EN
  // Reset to bs-1 so that the first scan starts at entry 0. Flush keeps this value.
  logic [BS_BITS-1:0] last_acc;
  logic               unused_rn;

  assign unused_rn = ^random_number;

  always_ff @(posedge clk) begin
    if (rst)         last_acc <= BS_BITS'(bs - 1);
    else if (accept) last_acc <= issue_index;
  end

  assign offset = last_acc + BS_BITS'(1);
`else
  assign offset = random_number;
`endif

  // Wrapping priority scan. The loop walks downward, so the entry closest to the
  // offset is written last and therefore wins.
  // Index arithmetic wraps for free because bs is a power of two.
  always_comb begin
    sel_idx  = '0;
    sel_hit  = 1'b0;
    scan_idx = '0;
    for (int k = bs - 1; k >= 0; k--) begin
      scan_idx = offset + BS_BITS'(k);
      if (eligible[scan_idx]) begin
        sel_idx = scan_idx;
        sel_hit = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (proceed && any_elig) state_next = S_SCAN;
      S_SCAN:  state_next = sel_hit ? S_ISSUE : S_IDLE;
      S_ISSUE: if (issue_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  // Outputs and datapath enables. Flush suppresses every side effect in its cycle.
  always_comb begin
    issue_valid = (state == S_ISSUE);
    accept      = issue_valid && issue_ready && !flush;
    load_idx    = (state == S_SCAN) && sel_hit && !flush;
    stall_inc   = (state == S_IDLE) && proceed && !any_elig && !flush;
  end

  // The index is latched only in SCAN, so mask changes during ISSUE cannot disturb it.
  always_ff @(posedge clk) begin
    if (rst)           issue_index <= '0;
    else if (load_idx) issue_index <= sel_idx;
  end

  // Per-entry busy update. The accept term is ORed in last, so a retire and an accept of
  // the same entry leave the bit set. A retire of an idle entry only clears a zero.
  for (genvar i = 0; i < bs; i++) begin : g_busy
    assign busy_next[i] = (busy_mask[i] & ~(retire_valid && (retire_index == BS_BITS'(i))))
                        | (accept && (issue_index == BS_BITS'(i)));
  end

  always_ff @(posedge clk) begin
    if (rst || flush) busy_mask <= '0;
    else              busy_mask <= busy_next;
  end

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_count <= '0;
      stall_count  <= '0;
    end else begin
      if (accept && (issued_count != {CNT_W{1'b1}}))
        issued_count <= issued_count + CNT_W'(1);
      if (stall_inc && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
